// File: rtl/store_buffer_if.sv
// store_buffer_if: store, memory-write and load-check signals of the store buffer.
//   st_*        : committed store from MEM stage (valid/ready)
//   mem_*       : head entry toward data memory write port (valid/ready)
//   ld_*        : load hazard check and optional forwarding result
//   sb_empty    : buffer holds no entries
// master = pipeline/memory side, slave = store buffer.
interface store_buffer_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            st_valid;
  logic            st_ready;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_wdata;
  logic [NB-1:0]   st_be;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_be;

  logic [XLEN-1:0] ld_addr;
  logic [NB-1:0]   ld_be;
  logic            ld_hazard;
  logic            ld_fwd_valid;
  logic [XLEN-1:0] ld_fwd_data;

  logic            sb_empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_be,
    input  st_ready,
    input  mem_req_valid, mem_addr, mem_wdata, mem_be,
    output mem_req_ready,
    output ld_addr, ld_be,
    input  ld_hazard, ld_fwd_valid, ld_fwd_data,
    input  sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_be,
    output st_ready,
    output mem_req_valid, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready,
    input  ld_addr, ld_be,
    output ld_hazard, ld_fwd_valid, ld_fwd_data,
    output sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores drained one per accepted
// memory write, with a combinational load-hazard check over held entries.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : store_buffer_if.slave (st_*, mem_*, ld_*, sb_empty)
// Optional build macro STBUF_FWD_EN: youngest-match byte forwarding to loads.
// Without it ld_fwd_valid/ld_fwd_data are tied to zero.
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = XLEN - OB;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [AW-1:0]   addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [NB-1:0]   be_q   [DEPTH];
  logic [NB-1:0]   be_d   [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW:0]     head_q, head_d, tail_q, tail_d;

  logic            full, empty, enq, deq;
  logic [PW-1:0]   head_idx, tail_idx;
  logic [DEPTH-1:0] match;
  logic            unused_lsbs;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
  assign enq      = bus.st_valid && !full && (bus.st_be != '0);
  assign deq      = !empty && bus.mem_req_ready;

  // Byte offsets are not stored; only word addresses are compared.
  assign unused_lsbs = ^{bus.st_addr[OB-1:0], bus.ld_addr[OB-1:0]};

  assign bus.st_ready      = !full;
  assign bus.sb_empty      = empty;
  assign bus.mem_req_valid = !empty;
  assign bus.mem_addr      = empty ? '0 : {addr_q[head_idx], {OB{1'b0}}};
  assign bus.mem_wdata     = empty ? '0 : data_q[head_idx];
  assign bus.mem_be        = empty ? '0 : be_q[head_idx];

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    be_d   = be_q;
    vld_d  = vld_q;
    if (deq) vld_d[head_idx] = 1'b0;
    if (enq) begin
      addr_d[tail_idx] = bus.st_addr[XLEN-1:OB];
      data_d[tail_idx] = bus.st_wdata;
      be_d[tail_idx]   = bus.st_be;
      vld_d[tail_idx]  = 1'b1;
    end
    head_d = head_q + {{PW{1'b0}}, deq};
    tail_d = tail_q + {{PW{1'b0}}, enq};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
      be_q   <= be_d;
    end
  end

  // Registered entries only; an entry draining this cycle still matches.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld_q[i] && (addr_q[i] == bus.ld_addr[XLEN-1:OB]) &&
                 ((be_q[i] & bus.ld_be) != '0);
    end
  end

`ifdef STBUF_FWD_EN
  logic          sel_found, sel_cover;
  logic [PW-1:0] sel_idx;

  // Walk back from the slot just below tail so the first hit is the youngest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!sel_found && match[tail_idx - PW'(k + 1)]) begin
        sel_found = 1'b1;
        sel_idx   = tail_idx - PW'(k + 1);
      end
    end
  end

  assign sel_cover        = ((be_q[sel_idx] & bus.ld_be) == bus.ld_be);
  assign bus.ld_fwd_valid = sel_found && sel_cover;
  assign bus.ld_hazard    = sel_found && !sel_cover;

  always_comb begin
    bus.ld_fwd_data = '0;
    if (bus.ld_fwd_valid) begin
      for (int j = 0; j < NB; j++) begin
        bus.ld_fwd_data[8*j +: 8] = data_q[sel_idx][8*j +: 8] & {8{bus.ld_be[j]}};
      end
    end
  end
`else
  assign bus.ld_hazard    = |match;
  assign bus.ld_fwd_valid = 1'b0;
  assign bus.ld_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed stores with a scoreboard of expected
// memory writes checked by an independent monitor, plus directed load checks.
module tb_store_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t sb_q[$];

  store_buffer_if #(.XLEN(32)) bus ();

  store_buffer #(.XLEN(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted memory write must equal the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_unexpected actual=%h required=none", bus.mem_addr);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_wdata", bus.mem_wdata, e.data);
        chk("mem_be", {28'd0, bus.mem_be}, {28'd0, e.be});
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input bit exp_acc, input bit chk_nonempty);
    wr_t e;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_wdata = d;
    bus.st_be    = be;
    @(negedge clk);
    chk("st_ready", {31'd0, bus.st_ready}, {31'd0, exp_acc});
    if (chk_nonempty) chk("sb_empty_stream", {31'd0, bus.sb_empty}, 32'd0);
    if (exp_acc && be != 4'd0) begin
      e.addr = a & 32'hFFFF_FFFC;
      e.data = d;
      e.be   = be;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.st_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.sb_empty === 1'b1) done = 1'b1;
    end
    chk({nm, "_drained"}, {31'd0, done}, 32'd1);
    chk({nm, "_queue_left"}, sb_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic ld_chk(input string nm, input logic [31:0] a, input logic [3:0] be,
                        input bit haz, input bit fv, input logic [31:0] fd);
    bus.ld_addr = a;
    bus.ld_be   = be;
    @(negedge clk);
    chk({nm, "_hazard"}, {31'd0, bus.ld_hazard}, {31'd0, haz});
    chk({nm, "_fwd_valid"}, {31'd0, bus.ld_fwd_valid}, {31'd0, fv});
    chk({nm, "_fwd_data"}, bus.ld_fwd_data, fd);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.st_valid = 1'b0;
    bus.st_addr = '0;
    bus.st_wdata = '0;
    bus.st_be = '0;
    bus.mem_req_ready = 1'b0;
    bus.ld_addr = '0;
    bus.ld_be = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_st_ready", {31'd0, bus.st_ready}, 32'd1);
    chk("rst_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_sb_empty", {31'd0, bus.sb_empty}, 32'd1);
    chk("rst_ld_hazard", {31'd0, bus.ld_hazard}, 32'd0);
    chk("rst_fwd_valid", {31'd0, bus.ld_fwd_valid}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk); #1;

    // Fill with memory stalled.
    for (int i = 0; i < 4; i++)
      drive_st(32'h100 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    chk("full_st_ready", {31'd0, bus.st_ready}, 32'd0);
    chk("full_sb_empty", {31'd0, bus.sb_empty}, 32'd0);
    chk("full_mem_valid", {31'd0, bus.mem_req_valid}, 32'd1);
    @(posedge clk); #1;

    // Full buffer: drain and store in same cycle -> store refused.
    bus.mem_req_ready = 1'b1;
    drive_st(32'h110, 32'h5555_5555, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("after_full_st_ready", {31'd0, bus.st_ready}, 32'd1);
    wait_drain("fill");

    // Streaming: occupancy one entry, pointers wrap.
    for (int i = 0; i < 10; i++)
      drive_st(32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b1, i > 0);
    wait_drain("stream");

    // Load hazard / forwarding on a single-byte store.
    bus.mem_req_ready = 1'b0;
    drive_st(32'h203, 32'hAB00_0000, 4'b1000, 1'b1, 1'b0);
    ld_chk("ld_other_lane", 32'h200, 4'b0001, 1'b0, 1'b0, 32'd0);
    ld_chk("ld_other_word", 32'h204, 4'b1000, 1'b0, 1'b0, 32'd0);
`ifdef STBUF_FWD_EN
    ld_chk("ld_same_lane", 32'h200, 4'b1000, 1'b0, 1'b1, 32'hAB00_0000);
`else
    ld_chk("ld_same_lane", 32'h200, 4'b1000, 1'b1, 1'b0, 32'd0);
`endif

    // Youngest match selection.
    drive_st(32'h300, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
    drive_st(32'h300, 32'h0000_BEEF, 4'b0011, 1'b1, 1'b0);
    ld_chk("ld_partial_cover", 32'h300, 4'hF, 1'b1, 1'b0, 32'd0);
    ld_chk("ld_miss", 32'h304, 4'hF, 1'b0, 1'b0, 32'd0);
`ifdef STBUF_FWD_EN
    ld_chk("ld_young_low", 32'h300, 4'b0011, 1'b0, 1'b1, 32'h0000_BEEF);
    ld_chk("ld_old_high", 32'h302, 4'b1100, 1'b0, 1'b1, 32'h1234_0000);
`else
    ld_chk("ld_young_low", 32'h300, 4'b0011, 1'b1, 1'b0, 32'd0);
    ld_chk("ld_old_high", 32'h302, 4'b1100, 1'b1, 1'b0, 32'd0);
`endif

    // Zero-byte-enable store is accepted but not stored: 3 entries stay 3.
    drive_st(32'h600, 32'h0000_DEAD, 4'b0000, 1'b1, 1'b0);
    @(negedge clk);
    chk("zero_be_st_ready", {31'd0, bus.st_ready}, 32'd1);
    @(posedge clk); #1;

    // Drain one, leaving two held, then reset with memory ready.
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("two_held_sb_empty", {31'd0, bus.sb_empty}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_req_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("rst2_sb_empty", {31'd0, bus.sb_empty}, 32'd1);
    chk("rst2_mem_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst2_st_ready", {31'd0, bus.st_ready}, 32'd1);
    chk("rst2_mem_be", {28'd0, bus.mem_be}, 32'd0);
    @(posedge clk); #1;
    ld_chk("rst2_ld", 32'h300, 4'hF, 1'b0, 1'b0, 32'd0);

    // Normal operation after reset.
    bus.mem_req_ready = 1'b1;
    drive_st(32'h700, 32'hCAFE_F00D, 4'b0110, 1'b1, 1'b0);
    wait_drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
